// File: rtl/nabp_processing_swap_control.sv
// Swap controller for NABP processing units A and B: issues iterations in order,
// advances the accumulator seeds and serialises the fill-to-shift swaps.
module nabp_processing_swap_control #(
    parameter int NUM_ITR   = 180,
    parameter int ITR_W     = 8,
    parameter int SH_W      = 10,
    parameter int MPI_W     = 12,
    parameter int MPB_W     = 12,
    parameter int SH_STEP   = 1,
    parameter int MPI_INIT0 = 0,
    parameter int MPI_STEP  = 3,
    parameter int MPB_INIT0 = 0,
    parameter int MPB_STEP  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             a_next_itr,
    input  logic             a_swap,
    output logic             a_next_itr_ack,
    output logic             a_swap_ack,
    input  logic             b_next_itr,
    input  logic             b_swap,
    output logic             b_next_itr_ack,
    output logic             b_swap_ack,
    output logic [SH_W-1:0]  sw_sh_accu_base,
    output logic [MPI_W-1:0] sw_mp_accu_init,
    output logic [MPB_W-1:0] sw_mp_accu_base,
    output logic [ITR_W-1:0] itr
);

    // state | meaning
    // IDLE  | waiting for start, no grants
    // RUN   | issuing iterations and granting swaps
    // DRAIN | all iterations issued, granting remaining swaps
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ITR_W:0]   NUM_ITR_X = (ITR_W+1)'(NUM_ITR);
    localparam logic [ITR_W-1:0] ITR_LAST  = ITR_W'(NUM_ITR);

    state_t state;
    logic   a_nia_q, b_nia_q, a_sa_q, b_sa_q;
    logic   rr;
    logic   sh_a, sh_b;
    logic   q0, q1;
    logic [1:0] q_cnt;

    logic   pending, can_issue, req_a, req_b;
    logic   grant_na, grant_nb, grant_sa, grant_sb, issue, pop;
    logic [ITR_W:0] itr_issued;

    // Registered acks are masked so they can never be seen high during reset.
    assign a_next_itr_ack = a_nia_q & reset_n;
    assign b_next_itr_ack = b_nia_q & reset_n;
    assign a_swap_ack     = a_sa_q & reset_n;
    assign b_swap_ack     = b_sa_q & reset_n;

    always_comb begin
        pending    = a_nia_q | b_nia_q;
        // An ack in flight has not yet advanced itr, so count it here.
        itr_issued = {1'b0, itr} + (ITR_W+1)'(pending);
        grant_sa   = (state != IDLE) && a_swap && !a_sa_q && (q_cnt != 2'd0) && !q0 && !sh_b;
        grant_sb   = (state != IDLE) && b_swap && !b_sa_q && (q_cnt != 2'd0) &&  q0 && !sh_a;
        req_a      = a_next_itr && !a_nia_q && !grant_sa;
        req_b      = b_next_itr && !b_nia_q && !grant_sb;
        can_issue  = (state == RUN) && (itr_issued < NUM_ITR_X) && (q_cnt != 2'd2);
        grant_na   = can_issue && req_a && (!req_b || !rr);
        grant_nb   = can_issue && req_b && (!req_a ||  rr);
        issue      = grant_na | grant_nb;
        pop        = grant_sa | grant_sb;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            a_nia_q         <= 1'b0;
            b_nia_q         <= 1'b0;
            a_sa_q          <= 1'b0;
            b_sa_q          <= 1'b0;
            rr              <= 1'b0;
            sh_a            <= 1'b0;
            sh_b            <= 1'b0;
            q0              <= 1'b0;
            q1              <= 1'b0;
            q_cnt           <= 2'd0;
            itr             <= '0;
            sw_sh_accu_base <= '0;
            sw_mp_accu_init <= MPI_W'(MPI_INIT0);
            sw_mp_accu_base <= MPB_W'(MPB_INIT0);
        end else begin
            done    <= 1'b0;
            a_nia_q <= grant_na;
            b_nia_q <= grant_nb;
            a_sa_q  <= grant_sa;
            b_sa_q  <= grant_sb;
            if (issue) rr <= ~rr;

            if (grant_sa)        sh_a <= 1'b1;
            else if (a_next_itr) sh_a <= 1'b0;
            if (grant_sb)        sh_b <= 1'b1;
            else if (b_next_itr) sh_b <= 1'b0;

            // Issue is blocked when full, so push+pop only happens with one entry.
            if (pop && issue) begin
                q0 <= grant_nb;
            end else if (pop) begin
                q0    <= q1;
                q_cnt <= q_cnt - 2'd1;
            end else if (issue) begin
                if (q_cnt == 2'd0) q0 <= grant_nb;
                else               q1 <= grant_nb;
                q_cnt <= q_cnt + 2'd1;
            end

            if (pending) begin
                itr             <= itr + ITR_W'(1);
                sw_sh_accu_base <= sw_sh_accu_base + SH_W'(SH_STEP);
                sw_mp_accu_init <= sw_mp_accu_init + MPI_W'(MPI_STEP);
                sw_mp_accu_base <= sw_mp_accu_base + MPB_W'(MPB_STEP);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= RUN;
                        busy            <= 1'b1;
                        rr              <= 1'b0;
                        itr             <= '0;
                        sw_sh_accu_base <= '0;
                        sw_mp_accu_init <= MPI_W'(MPI_INIT0);
                        sw_mp_accu_base <= MPB_W'(MPB_INIT0);
                    end
                end
                RUN: begin
                    if (itr == ITR_LAST) state <= DRAIN;
                end
                DRAIN: begin
                    if (!sh_a && !sh_b && (q_cnt == 2'd0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nabp_processing_swap_control.sv
// Directed bench for nabp_processing_swap_control: 4 iterations, 2-bit shifter seed
// with step 3 so the wrap sequence 0,3,2,1 is exercised.
module tb_nabp_processing_swap_control;

    localparam int NUM_ITR = 4;
    localparam int ITR_W   = 8;
    localparam int SH_W    = 2;
    localparam int MPI_W   = 12;
    localparam int MPB_W   = 12;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic a_next_itr = 1'b0, a_swap = 1'b0, b_next_itr = 1'b0, b_swap = 1'b0;
    logic busy, done;
    logic a_next_itr_ack, a_swap_ack, b_next_itr_ack, b_swap_ack;
    logic [SH_W-1:0]  sw_sh_accu_base;
    logic [MPI_W-1:0] sw_mp_accu_init;
    logic [MPB_W-1:0] sw_mp_accu_base;
    logic [ITR_W-1:0] itr;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_nia = 0, cnt_nib = 0, cnt_sa = 0, cnt_sb = 0, cnt_done = 0;

    nabp_processing_swap_control #(
        .NUM_ITR(NUM_ITR), .ITR_W(ITR_W), .SH_W(SH_W), .MPI_W(MPI_W), .MPB_W(MPB_W),
        .SH_STEP(3), .MPI_INIT0(0), .MPI_STEP(3), .MPB_INIT0(0), .MPB_STEP(5)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .a_next_itr(a_next_itr), .a_swap(a_swap),
        .a_next_itr_ack(a_next_itr_ack), .a_swap_ack(a_swap_ack),
        .b_next_itr(b_next_itr), .b_swap(b_swap),
        .b_next_itr_ack(b_next_itr_ack), .b_swap_ack(b_swap_ack),
        .sw_sh_accu_base(sw_sh_accu_base), .sw_mp_accu_init(sw_mp_accu_init),
        .sw_mp_accu_base(sw_mp_accu_base), .itr(itr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_next_itr_ack) cnt_nia  <= cnt_nia + 1;
        if (b_next_itr_ack) cnt_nib  <= cnt_nib + 1;
        if (a_swap_ack)     cnt_sa   <= cnt_sa + 1;
        if (b_swap_ack)     cnt_sb   <= cnt_sb + 1;
        if (done)           cnt_done <= cnt_done + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int acks();
        return int'({a_next_itr_ack, a_swap_ack, b_next_itr_ack, b_swap_ack});
    endfunction

    initial begin
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_itr", int'(itr), 0);
        chk("rst_sh", int'(sw_sh_accu_base), 0);
        chk("rst_mpi", int'(sw_mp_accu_init), 0);
        chk("rst_mpb", int'(sw_mp_accu_base), 0);
        chk("rst_acks", acks(), 0);
        reset_n = 1'b1;
        tick();

        // both units request every cycle
        start = 1'b1; a_next_itr = 1'b1; b_next_itr = 1'b1;
        tick();
        start = 1'b0;
        chk("run_busy", int'(busy), 1);
        chk("run_no_ack_yet", acks(), 0);
        tick();
        chk("issue0_a", int'({a_next_itr_ack, b_next_itr_ack}), 2);
        chk("issue0_itr", int'(itr), 0);
        tick();
        chk("issue1_b", int'({a_next_itr_ack, b_next_itr_ack}), 1);
        chk("issue1_itr", int'(itr), 1);
        chk("issue1_sh", int'(sw_sh_accu_base), 3);
        a_next_itr = 1'b0; b_next_itr = 1'b0;
        tick();
        chk("two_itr", int'(itr), 2);
        chk("two_sh", int'(sw_sh_accu_base), 2);
        chk("two_mpi", int'(sw_mp_accu_init), 6);
        chk("two_mpb", int'(sw_mp_accu_base), 10);
        chk("two_acks", acks(), 0);

        // start ignored in RUN; B asks to swap before the older A
        start = 1'b1; b_swap = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_itr", int'(itr), 2);
        chk("start_ignored_busy", int'(busy), 1);
        repeat (3) begin
            chk("b_swap_not_head", int'(b_swap_ack), 0);
            tick();
        end
        a_swap = 1'b1;
        tick();
        chk("a_swap_first", int'({a_swap_ack, b_swap_ack}), 2);
        a_swap = 1'b0;
        repeat (3) begin
            tick();
            chk("b_swap_wait_shift", int'(b_swap_ack), 0);
        end
        a_next_itr = 1'b1;
        tick();
        chk("issue2_a", int'(a_next_itr_ack), 1);
        chk("issue2_b_swap_low", int'(b_swap_ack), 0);
        a_next_itr = 1'b0;
        tick();
        chk("b_swap_after_a", int'(b_swap_ack), 1);
        chk("three_itr", int'(itr), 3);
        chk("three_sh", int'(sw_sh_accu_base), 1);
        chk("three_mpi", int'(sw_mp_accu_init), 9);
        chk("three_mpb", int'(sw_mp_accu_base), 15);
        b_swap = 1'b0; b_next_itr = 1'b1;
        tick();
        chk("issue3_b", int'(b_next_itr_ack), 1);
        b_next_itr = 1'b0; a_next_itr = 1'b1; a_swap = 1'b1;
        tick();
        chk("last_a_swap", int'(a_swap_ack), 1);
        chk("no_fifth_issue", int'(a_next_itr_ack), 0);
        chk("four_itr", int'(itr), 4);
        a_swap = 1'b0; b_swap = 1'b1;
        for (int k = 0; k < 10 && !b_swap_ack; k++) tick();
        chk("drain_b_swap", int'(b_swap_ack), 1);
        chk("drain_busy", int'(busy), 1);
        b_swap = 1'b0; b_next_itr = 1'b1;
        for (int k = 0; k < 10 && !done; k++) tick();
        chk("done_pulse", int'(done), 1);
        chk("busy_falls_with_done", int'(busy), 0);
        tick();
        chk("done_one_cycle", int'(done), 0);
        repeat (3) tick();
        chk("cnt_next_a", cnt_nia, 2);
        chk("cnt_next_b", cnt_nib, 2);
        chk("cnt_swap_a", cnt_sa, 2);
        chk("cnt_swap_b", cnt_sb, 2);
        chk("cnt_done", cnt_done, 1);
        chk("idle_itr", int'(itr), 4);

        // reset mid-run with an ack pending
        a_next_itr = 1'b0; b_next_itr = 1'b0;
        tick();
        start = 1'b1; a_next_itr = 1'b1; b_next_itr = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rerun_a_first", int'(a_next_itr_ack), 1);
        tick();
        chk("rerun_b", int'(b_next_itr_ack), 1);
        chk("rerun_itr", int'(itr), 1);
        reset_n = 1'b0;
        #1;
        chk("ack_masked_in_reset", acks(), 0);
        tick();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_itr", int'(itr), 0);
        chk("midrst_sh", int'(sw_sh_accu_base), 0);
        chk("midrst_mpb", int'(sw_mp_accu_base), 0);
        chk("midrst_acks", acks(), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_idle", int'(busy), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_a_first", int'({a_next_itr_ack, b_next_itr_ack}), 2);
        chk("restart_itr", int'(itr), 0);
        chk("restart_sh", int'(sw_sh_accu_base), 0);
        tick();
        chk("restart_b", int'({a_next_itr_ack, b_next_itr_ack}), 1);
        chk("restart_itr1", int'(itr), 1);
        chk("restart_mpi1", int'(sw_mp_accu_init), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
